mod_gen: RTL and testbench

- Upstream producer for the display manager: runs on the 100 MHz board clock and generates the 16-bit binary value shown on the 7-segment displays.
- Holds the slow-clock programming value `prog`, which sets the tick rate. Derives a slow tick enable from `prog`; no second clock tree.
- Runs one of two counting modules: Fibonacci or Timer.
- Outputs `prog`, `mod` and `data_2` feed the display manager directly.

---
 rtl/mod_gen_pkg.sv | 21 ++
 rtl/mod_gen_if.sv | 24 ++
 rtl/mod_gen_tick_gen.sv | 51 +++++
 rtl/mod_gen.sv | 135 +++++++++++++
 tb/tb_mod_gen.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mod_gen_pkg.sv
// Shared encodings and defaults for the mod_gen value generator.
package mod_gen_pkg;

  localparam logic [1:0] MOD_IDLE  = 2'd0;
  localparam logic [1:0] MOD_FIB   = 2'd1;
  localparam logic [1:0] MOD_TIMER = 2'd2;

  localparam int unsigned DATA_MAX_DEFAULT = 9999;

  typedef enum logic [1:0] {
    StIdle  = MOD_IDLE,
    StFib   = MOD_FIB,
    StTimer = MOD_TIMER
  } mod_state_e;

  // Slow-tick period in clk cycles for a given rate code.
  function automatic logic [31:0] tick_period(input int unsigned base, input logic [2:0] prog);
    return 32'(base) << prog;
  endfunction

endpackage

// File: rtl/mod_gen_if.sv
// Command/status bundle between mod_gen and its driver (buttons in, display manager out).
interface mod_gen_if;

  logic [2:0]  prog_in;
  logic        update;
  logic        start_f;
  logic        start_t;
  logic        stop;
  logic [2:0]  prog;
  logic [1:0]  mod;
  logic [15:0] data_2;
  logic        tick;

  modport slave (
    input  prog_in, update, start_f, start_t, stop,
    output prog, mod, data_2, tick
  );

  modport master (
    output prog_in, update, start_f, start_t, stop,
    input  prog, mod, data_2, tick
  );

endinterface

// File: rtl/mod_gen_tick_gen.sv
// Slow-tick enable generator: holds the rate code and strobes tick once per period.
module mod_gen_tick_gen
  import mod_gen_pkg::*;
#(
  parameter int unsigned TICK_BASE = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] prog_i,
  input  logic       update_i,
  input  logic       clr_i,
  output logic [2:0] prog_o,
  output logic       tick_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  prog_q, prog_d;
  logic        tick_q, tick_d;
  logic [31:0] period_d;

  // tick_q is high exactly while cnt_q sits at period-1, so it is decoded one edge early.
  always_comb begin
    prog_d = prog_q;
    if (update_i) begin
      prog_d = prog_i;
    end
    if (update_i || clr_i || tick_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    period_d = tick_period(TICK_BASE, prog_d);
    tick_d   = (cnt_d == period_d - 32'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prog_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prog_q <= prog_d;
      tick_q <= tick_d;
    end
  end

  assign prog_o = prog_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/mod_gen.sv
// Display value generator: Fibonacci or Timer stepped by a programmable slow tick.
// Define BTN_EDGE_EN to treat commands as raw button levels (synchronized, edge-detected).
module mod_gen
  import mod_gen_pkg::*;
#(
  parameter int unsigned TICK_BASE = 10_000_000,
  parameter int unsigned DATA_MAX  = DATA_MAX_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  mod_gen_if.slave bus
);

  logic update_c, start_f_c, start_t_c, stop_c;

`ifdef BTN_EDGE_EN
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q, prev_d;

  assign btn_raw = {bus.update, bus.start_f, bus.start_t, bus.stop};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // One pulse per press, taken from the synchronized rising edge.
  assign {update_c, start_f_c, start_t_c, stop_c} = sync2_q & ~prev_q;
`else
  assign update_c  = bus.update;
  assign start_f_c = bus.start_f;
  assign start_t_c = bus.start_t;
  assign stop_c    = bus.stop;
`endif

  logic tick;
  logic cnt_clr;

  // A start suppressed by a simultaneous stop must not disturb the tick phase.
  assign cnt_clr = ~stop_c & (start_f_c | start_t_c);

  mod_gen_tick_gen #(
    .TICK_BASE(TICK_BASE)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .prog_i  (bus.prog_in),
    .update_i(update_c),
    .clr_i   (cnt_clr),
    .prog_o  (bus.prog),
    .tick_o  (tick)
  );

  mod_state_e  state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] fib_sum;

  assign fib_sum = a_q + b_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    a_d     = a_q;
    b_d     = b_q;
    if (stop_c) begin
      state_d = StIdle;
      a_d     = 16'd0;
      b_d     = 16'd1;
    end else if (start_f_c) begin
      state_d = StFib;
      data_d  = 16'd0;
      a_d     = 16'd0;
      b_d     = 16'd1;
    end else if (start_t_c) begin
      state_d = StTimer;
      data_d  = 16'd0;
    end else if (tick) begin
      unique case (state_q)
        StFib: begin
          // A term that no longer fits on four digits restarts the sequence at 0.
          if (b_q > 16'(DATA_MAX)) begin
            data_d = 16'd0;
            a_d    = 16'd0;
            b_d    = 16'd1;
          end else begin
            data_d = b_q;
            a_d    = b_q;
            b_d    = fib_sum;
          end
        end
        StTimer: begin
          data_d = (data_q == 16'(DATA_MAX)) ? 16'd0 : data_q + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      a_q     <= 16'd0;
      b_q     <= 16'd1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.mod    = state_q;
  assign bus.data_2 = data_q;
  assign bus.tick   = tick;

endmodule

// File: tb/tb_mod_gen.sv
// Scoreboard bench for mod_gen with TICK_BASE=4; expected values queued ahead of each tick.
module tb_mod_gen;
  import mod_gen_pkg::*;

  localparam int unsigned TB_BASE = 4;

  logic clk = 1'b0;
  logic rst;

  mod_gen_if bus_if ();

  mod_gen #(
    .TICK_BASE(TB_BASE),
    .DATA_MAX (9999)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Pulse a command for one cycle; the button build needs two more edges to act.
  task automatic cmd(input logic u, input logic sf, input logic st, input logic sp,
                     input logic [2:0] p);
    bus_if.prog_in = p;
    bus_if.update  = u;
    bus_if.start_f = sf;
    bus_if.start_t = st;
    bus_if.stop    = sp;
    @(posedge clk); #1;
    bus_if.update  = 1'b0;
    bus_if.start_f = 1'b0;
    bus_if.start_t = 1'b0;
    bus_if.stop    = 1'b0;
`ifdef BTN_EDGE_EN
    repeat (2) begin
      @(posedge clk); #1;
    end
`endif
  endtask

  // Wait for the next tick, then compare data_2 after the edge against the scoreboard.
  task automatic wait_tick(input string tag, input int exp_iv);
    int n = 0;
    bit seen = 1'b0;
    logic [15:0] e;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus_if.tick === 1'b1) seen = 1'b1;
    end
    check({tag, "_tick_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    if (exp_iv > 0) check({tag, "_interval"}, n, exp_iv);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, bus_if.data_2, e);
    end
  endtask

  task automatic run_ticks(input string tag, input int count, input int exp_iv);
    for (int i = 0; i < count; i++) wait_tick(tag, exp_iv);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned fx, fy, ft;
    bus_if.prog_in = 3'd0;
    bus_if.update  = 1'b0;
    bus_if.start_f = 1'b0;
    bus_if.start_t = 1'b0;
    bus_if.stop    = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_prog", bus_if.prog, 0);
    check("rst_mod", bus_if.mod, MOD_IDLE);
    check("rst_data", bus_if.data_2, 0);
    check("rst_tick", bus_if.tick, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Timer at prog=0, then run through the 9999 -> 0 wrap.
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("tmr_start_mod", bus_if.mod, MOD_TIMER);
    check("tmr_start_data", bus_if.data_2, 0);
    for (int v = 1; v <= 3; v++) exp_q.push_back(16'(v));
    run_ticks("tmr", 3, 4);
    for (int v = 4; v <= 9999; v++) exp_q.push_back(16'(v));
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    run_ticks("tmr_wrap", 9998, 0);

    // Fibonacci: F1..F20, overflow shows 0, then restarts at 1.
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    check("fib_start_mod", bus_if.mod, MOD_FIB);
    check("fib_start_data", bus_if.data_2, 0);
    fx = 0;
    fy = 1;
    for (int i = 1; i <= 20; i++) begin
      exp_q.push_back(16'(fy));
      ft = fx + fy;
      fx = fy;
      fy = ft;
    end
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    run_ticks("fib", 22, 4);

    // Restart Fibonacci, stop at 55, switch to Timer.
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    fx = 0;
    fy = 1;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(16'(fy));
      ft = fx + fy;
      fx = fy;
      fy = ft;
    end
    run_ticks("fib55", 10, 4);
    check("fib55_value", bus_if.data_2, 55);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("switch_mod", bus_if.mod, MOD_TIMER);
    check("switch_data", bus_if.data_2, 0);

    // Rate change mid-count: period becomes 4 << 3 = 32.
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    run_ticks("tmr_p0", 2, 4);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    check("upd_prog", bus_if.prog, 3);
    check("upd_mod", bus_if.mod, MOD_TIMER);
    check("upd_data_held", bus_if.data_2, 2);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd4);
    run_ticks("tmr_p3", 2, 32);

    // Asynchronous reset mid-count, checked before the next clock edge.
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_prog", bus_if.prog, 0);
    check("arst_mod", bus_if.mod, MOD_IDLE);
    check("arst_data", bus_if.data_2, 0);
    check("arst_tick", bus_if.tick, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // stop beats start_f; start_f beats start_t.
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int v = 1; v <= 3; v++) exp_q.push_back(16'(v));
    run_ticks("tmr2", 3, 4);
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    check("stopprio_mod", bus_if.mod, MOD_IDLE);
    check("stopprio_data", bus_if.data_2, 3);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("idle_hold_data", bus_if.data_2, 3);
    check("idle_hold_mod", bus_if.mod, MOD_IDLE);
    cmd(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    check("fprio_mod", bus_if.mod, MOD_FIB);
    check("fprio_data", bus_if.data_2, 0);
    exp_q.push_back(16'd1);
    run_ticks("fprio_fib", 1, 4);

    // start_t held high for many cycles.
`ifdef BTN_EDGE_EN
    bus_if.start_t = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_mod", bus_if.mod, MOD_TIMER);
    check("hold_data", bus_if.data_2, 0);
    for (int v = 1; v <= 24; v++) exp_q.push_back(16'(v));
    run_ticks("hold_count", 24, 4);
    bus_if.start_t = 1'b0;
    exp_q.push_back(16'd25);
    run_ticks("hold_release", 1, 0);
`else
    bus_if.start_t = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_data", bus_if.data_2, 0);
      check("hold_mod", bus_if.mod, MOD_TIMER);
    end
    bus_if.start_t = 1'b0;
    exp_q.push_back(16'd1);
    run_ticks("hold_release", 1, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
